// File: rtl/key_debounce_ctrl.sv
// Key input stage: two-flop synchronisers, tick-paced debounce history and a
// per-key RELEASED/PRESSED FSM producing clean levels and press/release/long pulses.
module key_debounce_ctrl #(
  parameter int NKEY       = 4,
  parameter int DEB_CYCLES = 100000,
  parameter int CNT_W      = 17,
  parameter int STABLE_N   = 3,
  parameter int LONG_TICKS = 500,
  parameter int LONG_W     = 9
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [NKEY-1:0] iKEY_N,
  output logic            oTICK,
  output logic [NKEY-1:0] oKEY_LEVEL,
  output logic [NKEY-1:0] oKEY_PRESS,
  output logic [NKEY-1:0] oKEY_RELEASE,
  output logic [NKEY-1:0] oKEY_LONG
);

  typedef enum logic {
    KEY_RELEASED = 1'b0,
    KEY_PRESSED  = 1'b1
  } key_state_e;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tick_s;
  logic                tick_q, tick_d;
  logic [NKEY-1:0]     sync1_q, sync1_d;
  logic [NKEY-1:0]     sync2_q, sync2_d;
  logic [STABLE_N-1:0] hist_q [NKEY];
  logic [STABLE_N-1:0] hist_d [NKEY];
  key_state_e          state_q [NKEY];
  key_state_e          state_d [NKEY];
  logic [LONG_W-1:0]   long_cnt_q [NKEY];
  logic [LONG_W-1:0]   long_cnt_d [NKEY];
  logic [NKEY-1:0]     level_q, level_d;
  logic [NKEY-1:0]     press_q, press_d;
  logic [NKEY-1:0]     release_q, release_d;
  logic [NKEY-1:0]     long_q, long_d;

  // Prescaler, tick strobe and pin synchronisers
  always_comb begin
    tick_s = (cnt_q == CNT_W'(DEB_CYCLES - 1));
    if (tick_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d  = tick_s;
    sync1_d = ~iKEY_N;
    sync2_d = sync1_q;
  end

  // Per-key history, level FSM and long-press counter, all advanced on the tick only
  always_comb begin
    for (int k = 0; k < NKEY; k++) begin
      hist_d[k]     = hist_q[k];
      state_d[k]    = state_q[k];
      long_cnt_d[k] = long_cnt_q[k];
      press_d[k]    = 1'b0;
      release_d[k]  = 1'b0;
      long_d[k]     = 1'b0;
      if (tick_s) begin
        hist_d[k] = {hist_q[k][STABLE_N-2:0], sync2_q[k]};
        case (state_q[k])
          KEY_RELEASED: begin
            long_cnt_d[k] = {LONG_W{1'b0}};
            if (&hist_d[k]) begin
              state_d[k] = KEY_PRESSED;
              press_d[k] = 1'b1;
            end else begin
              state_d[k] = KEY_RELEASED;
            end
          end
          KEY_PRESSED: begin
            // Release takes priority over a long threshold reached on the same tick
            if (~|hist_d[k]) begin
              state_d[k]    = KEY_RELEASED;
              release_d[k]  = 1'b1;
              long_cnt_d[k] = {LONG_W{1'b0}};
            end else if (long_cnt_q[k] < LONG_W'(LONG_TICKS)) begin
              long_cnt_d[k] = long_cnt_q[k] + LONG_W'(1);
              if (long_cnt_d[k] == LONG_W'(LONG_TICKS)) begin
                long_d[k] = 1'b1;
              end else begin
                long_d[k] = 1'b0;
              end
            end else begin
              long_cnt_d[k] = long_cnt_q[k];
            end
          end
          default: begin
            state_d[k]    = KEY_RELEASED;
            long_cnt_d[k] = {LONG_W{1'b0}};
          end
        endcase
      end else begin
        hist_d[k] = hist_q[k];
      end
      level_d[k] = (state_d[k] == KEY_PRESSED);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt_q     <= {CNT_W{1'b0}};
      tick_q    <= 1'b0;
      sync1_q   <= {NKEY{1'b0}};
      sync2_q   <= {NKEY{1'b0}};
      level_q   <= {NKEY{1'b0}};
      press_q   <= {NKEY{1'b0}};
      release_q <= {NKEY{1'b0}};
      long_q    <= {NKEY{1'b0}};
      for (int k = 0; k < NKEY; k++) begin
        hist_q[k]     <= {STABLE_N{1'b0}};
        state_q[k]    <= KEY_RELEASED;
        long_cnt_q[k] <= {LONG_W{1'b0}};
      end
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      for (int k = 0; k < NKEY; k++) begin
        hist_q[k]     <= hist_d[k];
        state_q[k]    <= state_d[k];
        long_cnt_q[k] <= long_cnt_d[k];
      end
    end
  end

  assign oTICK        = tick_q;
  assign oKEY_LEVEL   = level_q;
  assign oKEY_PRESS   = press_q;
  assign oKEY_RELEASE = release_q;
  assign oKEY_LONG    = long_q;

endmodule

// File: tb/tb_key_debounce_ctrl.sv
// Directed bench for key_debounce_ctrl with a short prescaler (10 clocks/tick).
module tb_key_debounce_ctrl;
  localparam int NKEY = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NKEY-1:0] key_n;
  logic            tick;
  logic [NKEY-1:0] level, press, rel, lng;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int tick_cnt = 0;
  int align_err = 0;
  int press_cnt [NKEY];
  int rel_cnt   [NKEY];
  int long_cnt  [NKEY];
  int press_tick[NKEY];
  int rel_tick  [NKEY];
  int long_tick [NKEY];
  int base;
  int total;

  key_debounce_ctrl #(
    .NKEY(4), .DEB_CYCLES(10), .CNT_W(4), .STABLE_N(3), .LONG_TICKS(5), .LONG_W(3)
  ) dut (
    .iCLK(clk), .iRST(rst), .iKEY_N(key_n), .oTICK(tick), .oKEY_LEVEL(level),
    .oKEY_PRESS(press), .oKEY_RELEASE(rel), .oKEY_LONG(lng)
  );

  always #5 clk = ~clk;

  // Advance one clock, sample #1 after the edge and log pulse events
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (tick === 1'b1) tick_cnt++;
    if (((press | rel | lng) != 4'b0000) && (tick !== 1'b1)) align_err++;
    if ((press & rel) != 4'b0000) align_err++;
    for (int k = 0; k < NKEY; k++) begin
      if (press[k] === 1'b1) begin press_cnt[k]++; press_tick[k] = tick_cnt; end
      if (rel[k] === 1'b1)   begin rel_cnt[k]++;   rel_tick[k]   = tick_cnt; end
      if (lng[k] === 1'b1)   begin long_cnt[k]++;  long_tick[k]  = tick_cnt; end
    end
  endtask

  task automatic align_tick();
    int i;
    i = 0;
    do begin
      step();
      i++;
    end while ((tick !== 1'b1) && (i < 20));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NKEY; k++) begin
      press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0;
      press_tick[k] = -1; rel_tick[k] = -1; long_tick[k] = -1;
    end
    rst   = 1'b1;
    key_n = 4'hF;
    repeat (3) step();
    chk("reset_outputs", {tick, level, press, rel, lng}, 32'h0);

    // Idle: first tick exactly 10 clocks after reset release, then every 10
    rst = 1'b0;
    cyc = 0;
    tick_cnt = 0;
    repeat (9) step();
    chk("no_tick_before_clk10", tick_cnt, 0);
    step();
    chk("first_tick_clk10", tick, 1'b1);
    repeat (190) step();
    chk("idle_tick_count", tick_cnt, 20);
    total = 0;
    for (int k = 0; k < NKEY; k++) total += press_cnt[k] + rel_cnt[k] + long_cnt[k];
    chk("idle_no_pulses", total, 0);
    chk("idle_level", level, 4'b0000);

    // Key 0 press: driven just after a tick, fires on the 3rd tick (clock 230)
    key_n[0] = 1'b0;
    base = tick_cnt;
    for (int i = 0; i < 60 && press_cnt[0] == 0; i++) step();
    chk("k0_press_vec", press, 4'b0001);
    chk("k0_press_with_tick", tick, 1'b1);
    chk("k0_press_3rd_tick", press_tick[0], base + 3);
    chk("k0_press_cycle", cyc, 230);
    step();
    chk("k0_press_width", press, 4'b0000);
    chk("k0_level", level, 4'b0001);

    // Key 1 toggling every 15 clocks never yields 3 equal samples
    for (int t = 0; t < 20; t++) begin
      key_n[1] = ~key_n[1];
      repeat (15) step();
    end
    chk("k1_no_press", press_cnt[1], 0);
    chk("k1_no_release", rel_cnt[1], 0);
    chk("k1_level", level[1], 1'b0);
    chk("k0_long_once", long_cnt[0], 1);
    chk("k0_long_5_ticks", long_tick[0], press_tick[0] + 5);
    chk("k0_no_release", rel_cnt[0], 0);

    // Key 2 held 12 ticks then released
    align_tick();
    key_n[2] = 1'b0;
    base = tick_cnt;
    for (int i = 0; i < 60 && press_cnt[2] == 0; i++) step();
    chk("k2_press_3rd_tick", press_tick[2], base + 3);
    for (int i = 0; i < 200 && tick_cnt < press_tick[2] + 12; i++) step();
    chk("k2_long_once", long_cnt[2], 1);
    chk("k2_long_5_ticks", long_tick[2], press_tick[2] + 5);
    key_n[2] = 1'b1;
    base = tick_cnt;
    for (int i = 0; i < 60 && rel_cnt[2] == 0; i++) step();
    chk("k2_release_vec", rel, 4'b0100);
    chk("k2_release_3rd_tick", rel_tick[2], base + 3);
    repeat (100) step();
    chk("k2_single_release", rel_cnt[2], 1);
    chk("k2_no_second_long", long_cnt[2], 1);
    chk("k2_level", level[2], 1'b0);

    // Release key 0, then press keys 0 and 3 in the same clock
    align_tick();
    key_n[0] = 1'b1;
    base = tick_cnt;
    for (int i = 0; i < 60 && rel_cnt[0] == 0; i++) step();
    chk("k0_release_3rd_tick", rel_tick[0], base + 3);
    chk("k0_no_second_long", long_cnt[0], 1);
    align_tick();
    key_n = 4'b0110;
    base = tick_cnt;
    for (int i = 0; i < 60 && press == 4'b0000; i++) step();
    chk("k03_press_vec", press, 4'b1001);
    chk("k03_press_3rd_tick", press_tick[3], base + 3);
    step();
    chk("k03_level", level, 4'b1001);

    // Reset while keys are held: no release pulse, then fresh press after 3 ticks
    repeat (25) step();
    chk("pre_reset_level", level, 4'b1001);
    total = rel_cnt[0] + rel_cnt[3];
    rst = 1'b1;
    step();
    chk("reset_mid_outputs", {tick, level, press, rel, lng}, 32'h0);
    chk("reset_no_release", rel_cnt[0] + rel_cnt[3], total);
    rst = 1'b0;
    cyc = 0;
    base = tick_cnt;
    for (int i = 0; i < 60 && press == 4'b0000; i++) step();
    chk("post_reset_press_vec", press, 4'b1001);
    chk("post_reset_press_cycle", cyc, 30);
    chk("post_reset_press_tick", press_tick[0], base + 3);
    chk("reset_no_long", long_cnt[0], 1);

    chk("pulse_alignment", align_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
